// File: rtl/sound_pkg.sv
// Shared types and constant tables for the sound effect sequencer:
// note prescale table, effect ids, effect step ROM and FSM states.
package sound_pkg;

  // Effect ids double as priorities: a lower value wins.
  typedef enum logic [1:0] {
    EFF_COLLISION = 2'd0,
    EFF_PFIRE     = 2'd1,
    EFF_MFIRE     = 2'd2,
    EFF_JINGLE    = 2'd3
  } effect_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // One note of an effect: note index, length in ms, end-of-effect marker.
  typedef struct packed {
    logic [3:0] note;
    logic [7:0] dur_ms;
    logic       last;
  } step_t;

  localparam int NUM_EFFECTS      = 4;
  localparam int STEPS_PER_EFFECT = 4;

  // Value the tone generator sees out of reset (same as note 0).
  localparam logic [9:0] PRESCALE_RESET = 10'h1D6;

  // Prescale values, 31.5 MHz / 256 / f.
  localparam logic [9:0] NOTE_TABLE [16] = '{
    10'h1D6, 10'h1BC, 10'h1A3, 10'h18B,
    10'h175, 10'h160, 10'h14D, 10'h13A,
    10'h128, 10'h118, 10'h108, 10'h0F9,
    10'h0EB, 10'h0DD, 10'h0D1, 10'h0C5
  };

  // Filler for unused ROM slots; never reached because a real step ends
  // the effect earlier, but keeps the ROM free of zero durations.
  localparam step_t STEP_NONE = '{4'd0, 8'd1, 1'b1};

  // Effect ROM indexed [effect id][step].
  localparam step_t EFFECT_ROM [NUM_EFFECTS][STEPS_PER_EFFECT] = '{
    '{ '{4'd2,  8'd40,  1'b0}, '{4'd0,  8'd40,  1'b1}, STEP_NONE, STEP_NONE },
    '{ '{4'd3,  8'd30,  1'b1}, STEP_NONE, STEP_NONE, STEP_NONE },
    '{ '{4'd6,  8'd20,  1'b0}, '{4'd9,  8'd20,  1'b1}, STEP_NONE, STEP_NONE },
    '{ '{4'd7,  8'd100, 1'b0}, '{4'd9,  8'd100, 1'b0},
       '{4'd11, 8'd100, 1'b0}, '{4'd12, 8'd100, 1'b1} }
  };

  // Priority encoder: lowest set bit is the highest-priority effect.
  function automatic effect_id_t highest_pending(input logic [3:0] pend);
    effect_id_t id;
    id = EFF_COLLISION;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) begin
        id = effect_id_t'(i[1:0]);
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/sound_tick_gen.sv
// Duration tick prescaler: counts 0..TICK_CYCLES-1 and wraps, with a
// synchronous clear so every note starts on a fresh tick phase.
module sound_tick_gen #(
  parameter int TICK_CYCLES = 31500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sound_effect_sequencer.sv
// Sound effect sequencer: latches game event pulses, picks the
// highest-priority effect and steps through its notes on the single tone
// generator, with preemption by higher-priority effects.
module sound_effect_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_CYCLES = 31500
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [9:0] preScaleValue,
  output logic       enabler,
  output logic       busy,
  output logic [1:0] active_id
);

  state_t     state_q,     state_d;
  effect_id_t active_id_q, active_id_d;
  logic [3:0] pending_q,   pending_d;
  logic [1:0] step_q,      step_d;
  logic [7:0] dur_cnt_q,   dur_cnt_d;
  logic [9:0] prescale_q,  prescale_d;
  logic       en_q,        en_d;

  logic       tick;
  logic       tick_clr;
  logic       is_busy;
  logic [3:0] active_mask;
  logic [3:0] req_accept;
  logic [3:0] load_mask;
  effect_id_t top_id;
  logic       preempt;
  step_t      cur_step;

  assign is_busy     = (state_q != ST_IDLE);
  assign active_mask = 4'b0001 << active_id_q;
  // A request for the effect already running is dropped, not queued.
  assign req_accept  = is_busy ? (req & ~active_mask) : req;
  assign top_id      = highest_pending(pending_q);
  assign preempt     = (|pending_q) && (top_id < active_id_q);
  assign cur_step    = EFFECT_ROM[active_id_q][step_q];
  assign tick_clr    = (state_q == ST_LOAD);

  sound_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst_n (resetN),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Next-state logic: effect selection, note loading and duration countdown.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    step_d      = step_q;
    dur_cnt_d   = dur_cnt_q;
    prescale_d  = prescale_q;
    en_d        = en_q;
    load_mask   = 4'b0000;

    unique case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d     = ST_LOAD;
          active_id_d = top_id;
          step_d      = 2'd0;
          load_mask   = 4'b0001 << top_id;
        end
      end

      ST_LOAD: begin
        if (preempt) begin
          // Restart loading with the more urgent effect; the old one is dropped.
          state_d     = ST_LOAD;
          active_id_d = top_id;
          step_d      = 2'd0;
          load_mask   = 4'b0001 << top_id;
        end else begin
          prescale_d = NOTE_TABLE[cur_step.note];
          dur_cnt_d  = cur_step.dur_ms;
          en_d       = 1'b1;
          state_d    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (preempt) begin
          state_d     = ST_LOAD;
          active_id_d = top_id;
          step_d      = 2'd0;
          load_mask   = 4'b0001 << top_id;
        end else if (tick) begin
          dur_cnt_d = dur_cnt_q - 8'd1;
          if (dur_cnt_q == 8'd1) begin
            if (cur_step.last) begin
              state_d = ST_IDLE;
              en_d    = 1'b0;
            end else begin
              step_d  = step_q + 2'd1;
              state_d = ST_LOAD;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    // New requests are folded in before the loaded effect's bit is cleared,
    // so a same-cycle retrigger of the effect being loaded is absorbed.
    pending_d = (pending_q | req_accept) & ~load_mask;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      active_id_q <= EFF_COLLISION;
      pending_q   <= 4'b0000;
      step_q      <= 2'd0;
      dur_cnt_q   <= 8'd0;
      prescale_q  <= PRESCALE_RESET;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      pending_q   <= pending_d;
      step_q      <= step_d;
      dur_cnt_q   <= dur_cnt_d;
      prescale_q  <= prescale_d;
      en_q        <= en_d;
    end
  end

  assign preScaleValue = prescale_q;
  assign enabler       = en_q & ~mute;
  assign busy          = is_busy;
  assign active_id     = active_id_q;

endmodule

// File: tb/tb_sound_effect_sequencer.sv
// Testbench for sound_effect_sequencer (TICK_CYCLES = 4): a vector table of
// single-snapshot checks, then hand-written sequences whose note stream is
// checked by a note scoreboard.
module tb_sound_effect_sequencer;

  localparam int TICK = 4;

  logic       clk    = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] req    = 4'b0000;
  logic       mute   = 1'b0;
  logic [9:0] psv;
  logic       en;
  logic       busy;
  logic [1:0] aid;

  sound_effect_sequencer #(.TICK_CYCLES(TICK)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .req          (req),
    .mute         (mute),
    .preScaleValue(psv),
    .enabler      (en),
    .busy         (busy),
    .active_id    (aid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // ---------------- note scoreboard ----------------
  typedef struct {
    logic [9:0] psv;
    int         len;   // cycles the note value is held while busy; 0 = truncated
  } note_t;

  note_t      sb_q[$];
  bit         sb_on = 1'b0;
  bit         seg_open = 1'b0;
  logic [9:0] seg_psv;
  logic [9:0] prev_psv;
  int         seg_len = 0;

  task automatic push_note(input logic [9:0] p, input int len);
    note_t e;
    e.psv = p;
    e.len = len;
    sb_q.push_back(e);
  endtask

  task automatic close_seg();
    note_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected_note: actual %0h len %0d required none", seg_psv, seg_len);
    end else begin
      e = sb_q.pop_front();
      check("sb_note_psv", 32'(seg_psv), 32'(e.psv));
      if (e.len != 0) check("sb_note_len", 32'(seg_len), 32'(e.len));
    end
  endtask

  // Segments a note as the span where busy is high and preScaleValue is stable.
  always @(negedge clk) begin
    if (!sb_on) begin
      seg_open = 1'b0;
      prev_psv = psv;
    end else begin
      if (seg_open) begin
        if (busy === 1'b1 && psv === seg_psv) begin
          seg_len++;
        end else begin
          close_seg();
          seg_open = 1'b0;
        end
      end
      if (!seg_open && busy === 1'b1 && psv !== prev_psv) begin
        seg_open = 1'b1;
        seg_psv  = psv;
        seg_len  = 1;
      end
      prev_psv = psv;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Drives a one-cycle pulse; returns at the negedge after the sampling edge.
  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    req = v;
    @(posedge clk);
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Waits until busy has been low for 3 consecutive cycles, bounded.
  task automatic wait_quiet(input int max_cycles, input string name);
    int c = 0;
    int quiet = 0;
    while (quiet < 3 && c < max_cycles) begin
      @(negedge clk);
      c++;
      if (busy === 1'b0) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 3) begin
      n_bad++;
      $display("FAIL %s_timeout: actual busy after %0d cycles required idle", name, c);
    end
  endtask

  // Counts busy cycles over a window; nothing may start.
  task automatic expect_idle_for(input int n, input string name);
    int hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  // Asynchronous reset between edges, outputs checked before any edge.
  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check({name, "_en"},   32'(en),   32'd0);
    check({name, "_psv"},  32'(psv),  32'h1D6);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_aid"},  32'(aid),  32'd0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic       mute;
    int         n;       // edges after the edge that samples req
    logic [9:0] psv;
    logic       en;
    logic       busy;
    logic [1:0] aid;
    logic       chk_id;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 0,   10'h1D6, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{4'b0001, 1'b0, 1,   10'h1D6, 1'b0, 1'b1, 2'd0, 1'b1};
    vecs[2]  = '{4'b0001, 1'b0, 2,   10'h1A3, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[3]  = '{4'b0001, 1'b0, 161, 10'h1A3, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{4'b0001, 1'b0, 162, 10'h1A3, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[5]  = '{4'b0001, 1'b0, 163, 10'h1D6, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[6]  = '{4'b0001, 1'b0, 322, 10'h1D6, 1'b1, 1'b1, 2'd0, 1'b1};
    vecs[7]  = '{4'b0001, 1'b0, 323, 10'h1D6, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{4'b0010, 1'b0, 2,   10'h18B, 1'b1, 1'b1, 2'd1, 1'b1};
    vecs[9]  = '{4'b0010, 1'b0, 121, 10'h18B, 1'b1, 1'b1, 2'd1, 1'b1};
    vecs[10] = '{4'b0010, 1'b0, 122, 10'h18B, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{4'b0100, 1'b1, 2,   10'h14D, 1'b0, 1'b1, 2'd2, 1'b1};
    vecs[12] = '{4'b0100, 1'b1, 82,  10'h14D, 1'b0, 1'b1, 2'd2, 1'b1};
    vecs[13] = '{4'b0100, 1'b1, 83,  10'h118, 1'b0, 1'b1, 2'd2, 1'b1};
    vecs[14] = '{4'b0100, 1'b0, 162, 10'h118, 1'b1, 1'b1, 2'd2, 1'b1};
    vecs[15] = '{4'b0100, 1'b0, 163, 10'h118, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[16] = '{4'b1000, 1'b0, 2,   10'h13A, 1'b1, 1'b1, 2'd3, 1'b1};
    vecs[17] = '{4'b1000, 1'b0, 403, 10'h118, 1'b1, 1'b1, 2'd3, 1'b1};
    vecs[18] = '{4'b0110, 1'b0, 2,   10'h18B, 1'b1, 1'b1, 2'd1, 1'b1};
    vecs[19] = '{4'b1111, 1'b0, 2,   10'h1A3, 1'b1, 1'b1, 2'd0, 1'b1};

    for (int i = 0; i < NV; i++) begin
      do_reset();
      mute = vecs[i].mute;
      if (vecs[i].req != 4'b0000) pulse(vecs[i].req);
      edges(vecs[i].n);
      check($sformatf("v%0d_psv", i),  32'(psv),  32'(vecs[i].psv));
      check($sformatf("v%0d_en", i),   32'(en),   32'(vecs[i].en));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      if (vecs[i].chk_id) check($sformatf("v%0d_aid", i), 32'(aid), 32'(vecs[i].aid));
      mute = 1'b0;
    end

    // ---------------- hand-written sequences ----------------
    do_reset();
    sb_on = 1'b1;

    // Collision: two notes, then silence.
    push_note(10'h1A3, 161);
    push_note(10'h1D6, 160);
    pulse(4'b0001);
    wait_quiet(1000, "s1");
    @(negedge clk);
    check("s1_en_idle", 32'(en), 32'd0);
    check("s1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Player fire with a retrigger mid-note that must be ignored.
    push_note(10'h18B, 120);
    pulse(4'b0010);
    edges(60);
    pulse(4'b0010);
    check("s2_aid", 32'(aid), 32'd1);
    wait_quiet(500, "s2");
    expect_idle_for(200, "s2_no_replay");
    check("s2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Jingle preempted by collision during its second note.
    push_note(10'h13A, 401);
    push_note(10'h118, 0);
    pulse(4'b1000);
    edges(500);
    push_note(10'h1A3, 161);
    push_note(10'h1D6, 160);
    pulse(4'b0001);
    edges(1);
    check("s3_load_en", 32'(en), 32'd1);
    check("s3_load_aid", 32'(aid), 32'd0);
    check("s3_load_psv", 32'(psv), 32'h118);
    edges(1);
    check("s3_preempt_psv", 32'(psv), 32'h1A3);
    check("s3_preempt_en", 32'(en), 32'd1);
    wait_quiet(1000, "s3");
    expect_idle_for(600, "s3_no_resume");
    check("s3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Player fire and monster fire together: served in priority order.
    push_note(10'h18B, 120);
    push_note(10'h14D, 81);
    push_note(10'h118, 80);
    pulse(4'b0110);
    edges(2);
    check("s4_first_psv", 32'(psv), 32'h18B);
    check("s4_first_aid", 32'(aid), 32'd1);
    edges(100);
    check("s4_still_pfire", 32'(aid), 32'd1);
    wait_quiet(1000, "s4");
    check("s4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Muted monster fire, released mid-note; timing unaffected.
    mute = 1'b1;
    push_note(10'h14D, 81);
    push_note(10'h118, 80);
    pulse(4'b0100);
    edges(2);
    check("s5_mute_en", 32'(en), 32'd0);
    check("s5_mute_busy", 32'(busy), 32'd1);
    edges(40);
    check("s5_mute_en_mid", 32'(en), 32'd0);
    mute = 1'b0;
    #1;
    check("s5_unmute_en", 32'(en), 32'd1);
    wait_quiet(500, "s5");
    check("s5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of the jingle.
    push_note(10'h13A, 0);
    pulse(4'b1000);
    edges(200);
    async_reset_check("s6_rst");
    expect_idle_for(100, "s6_after_rst");

    // Reset drops a pending jingle queued behind a collision.
    push_note(10'h1A3, 0);
    pulse(4'b1001);
    edges(50);
    check("s6b_aid", 32'(aid), 32'd0);
    async_reset_check("s6b_rst");
    expect_idle_for(700, "s6b_pending_lost");
    check("s6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
